tlc_monitor: RTL and testbench

Passive checker on the lamp side of the traffic-light controller. Samples `red`, `yellow` and `green` every clock and checks three things: one-hot lamp encoding, the legal phase order (red → green → yellow → red), and exact per-phase durations. Reports the first violation as a sticky error code and counts completed clean cycles. Used in simulation and as an on-chip health monitor next to the controller/datapath pair; it never drives the lamps.

---
 rtl/tlc_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_tlc_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_monitor.sv
// Passive lamp-side checker: one-hot encoding, red->green->yellow order, optional exact phase lengths
// (`TLC_MON_DURATION_CHECK_EN); registered outputs, errors visible right after the offending edge, never stalls.
module tlc_monitor #(
  parameter int RED_CYCLES    = 10,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  input  logic       err_clr,
  output logic       err,
  output logic [2:0] err_code,
  output logic [1:0] phase,
  output logic [7:0] cycles
);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_RED    = 2'd1,
    S_GREEN  = 2'd2,
    S_YELLOW = 2'd3
  } state_t;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_ENC   = 3'd1;
  localparam logic [2:0] E_TRANS = 3'd2;
  localparam logic [2:0] E_SHORT = 3'd3;
  localparam logic [2:0] E_LONG  = 3'd4;

  if (RED_CYCLES < 1 || RED_CYCLES > 30 || GREEN_CYCLES < 1 || GREEN_CYCLES > 30 ||
      YELLOW_CYCLES < 1 || YELLOW_CYCLES > 30) begin : g_param_check
    $error("tlc_monitor: phase lengths must lie in 1..30");
  end

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  state_t     state_q, state_d;
  logic [2:0] prev_q;
  logic [7:0] cycles_q, cycles_d;
  logic       err_q, err_d;
  logic [2:0] code_q, code_d;
  logic [2:0] new_code;
  logic [2:0] smp;
  logic       smp_onehot, prev_onehot;
  state_t     lamp_st, succ_st;

  assign smp         = {red, green, yellow};
  assign smp_onehot  = is_onehot(smp);
  assign prev_onehot = is_onehot(prev_q);

  always_comb begin
    case (smp)
      3'b100:  lamp_st = S_RED;
      3'b010:  lamp_st = S_GREEN;
      3'b001:  lamp_st = S_YELLOW;
      default: lamp_st = S_SYNC;
    endcase
  end

  always_comb begin
    case (state_q)
      S_RED:    succ_st = S_GREEN;
      S_GREEN:  succ_st = S_YELLOW;
      S_YELLOW: succ_st = S_RED;
      default:  succ_st = S_SYNC;
    endcase
  end

`ifdef TLC_MON_DURATION_CHECK_EN
  // chk_q: current phase was entered from another phase, so its length is fully known.
  // clean_q: the current RED..YELLOW run began with a fully checked red.
  logic [4:0] cnt_q, cnt_d, lim;
  logic       chk_q, chk_d;
  logic       clean_q, clean_d;

  always_comb begin
    case (state_q)
      S_RED:    lim = 5'(RED_CYCLES);
      S_GREEN:  lim = 5'(GREEN_CYCLES);
      S_YELLOW: lim = 5'(YELLOW_CYCLES);
      default:  lim = 5'd31;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    new_code = E_NONE;
`ifdef TLC_MON_DURATION_CHECK_EN
    cnt_d    = cnt_q;
    chk_d    = chk_q;
    clean_d  = clean_q;
`endif
    if (!smp_onehot) begin
      new_code = E_ENC;
    end else if (state_q == S_SYNC) begin
      // A lamp that was already lit when we started watching is not a phase start.
      if (prev_onehot && (smp != prev_q)) begin
        state_d = lamp_st;
`ifdef TLC_MON_DURATION_CHECK_EN
        cnt_d   = 5'd1;
        chk_d   = 1'b0;
        clean_d = 1'b0;
`endif
      end
    end else if (lamp_st == state_q) begin
`ifdef TLC_MON_DURATION_CHECK_EN
      if (cnt_q == lim) begin
        new_code = E_LONG;
      end else if (cnt_q != 5'd31) begin
        cnt_d = cnt_q + 5'd1;
      end
`endif
    end else if (lamp_st != succ_st) begin
      new_code = E_TRANS;
`ifdef TLC_MON_DURATION_CHECK_EN
    end else if (chk_q && (cnt_q < lim)) begin
      new_code = E_SHORT;
`endif
    end else begin
      state_d = lamp_st;
`ifdef TLC_MON_DURATION_CHECK_EN
      cnt_d = 5'd1;
      chk_d = 1'b1;
      if (state_q == S_YELLOW) begin
        if (clean_q) begin
          cycles_d = cycles_q + 8'd1;
        end
        clean_d = 1'b1;
      end
`else
      if (state_q == S_YELLOW) begin
        cycles_d = cycles_q + 8'd1;
      end
`endif
    end

    if (new_code != E_NONE) begin
      state_d = S_SYNC;
`ifdef TLC_MON_DURATION_CHECK_EN
      cnt_d   = 5'd0;
      chk_d   = 1'b0;
      clean_d = 1'b0;
`endif
    end
  end

  // Clear first, then let a same-edge error win; otherwise only the first error is kept.
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (err_clr) begin
      err_d  = 1'b0;
      code_d = E_NONE;
    end
    if ((new_code != E_NONE) && (!err_q || err_clr)) begin
      err_d  = 1'b1;
      code_d = new_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_SYNC;
      prev_q   <= 3'b000;
      cycles_q <= 8'd0;
      err_q    <= 1'b0;
      code_q   <= E_NONE;
    end else begin
      state_q  <= state_d;
      prev_q   <= smp;
      cycles_q <= cycles_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

`ifdef TLC_MON_DURATION_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 5'd0;
      chk_q   <= 1'b0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      clean_q <= clean_d;
    end
  end
`endif

  assign err      = err_q;
  assign err_code = code_q;
  assign phase    = state_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_tlc_monitor.sv
// Bench for tlc_monitor: directed scenarios plus randomized lamp traffic against a phase-list reference model.
module tb_tlc_monitor;

`ifdef TLC_MON_DURATION_CHECK_EN
  localparam bit DUR = 1'b1;
`else
  localparam bit DUR = 1'b0;
`endif

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       red = 1'b0, yellow = 1'b0, green = 1'b0, err_clr = 1'b0;
  logic       err;
  logic [2:0] err_code;
  logic [1:0] phase;
  logic [7:0] cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lamp id 0 = not locked, 1 red, 2 green, 3 yellow.
  int         req[4] = '{0, 10, 8, 3};
  int         m_lamp, m_seen, m_nph, m_cycles, m_code;
  bit         m_err;
  logic [2:0] m_prev;

  tlc_monitor dut (
    .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
    .err_clr(err_clr), .err(err), .err_code(err_code), .phase(phase), .cycles(cycles)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [2:0] s);
    case (s)
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] lampv(input int id);
    case (id)
      1:       return R;
      2:       return G;
      default: return Y;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_lamp = 0; m_seen = 0; m_nph = 0; m_cycles = 0;
    m_code = 0; m_err = 1'b0; m_prev = 3'b000;
  endtask

  // m_nph counts phases entered since the monitor locked on; a red is fully
  // checked only if it was not the first of them.
  task automatic model_edge(input logic [2:0] s, input logic clr);
    int li, pi, code;
    li = idx(s); pi = idx(m_prev); code = 0;
    if (li == 0) code = 1;
    else if (m_lamp == 0) begin
      if (pi != 0 && li != pi) begin m_lamp = li; m_seen = 1; m_nph = 1; end
    end else if (li == m_lamp) begin
      if (DUR && m_seen >= req[m_lamp]) code = 4;
      else m_seen++;
    end else if (li != (m_lamp % 3) + 1) code = 2;
    else if (DUR && m_nph > 1 && m_seen < req[m_lamp]) code = 3;
    else begin
      if (m_lamp == 3 && (!DUR || m_nph >= 4)) m_cycles = (m_cycles + 1) % 256;
      m_lamp = li; m_seen = 1; m_nph++;
    end
    if (code != 0) begin m_lamp = 0; m_nph = 0; end
    if (code != 0 && (!m_err || clr)) begin m_err = 1'b1; m_code = code; end
    else if (clr) begin m_err = 1'b0; m_code = 0; end
    m_prev = s;
  endtask

  task automatic step(input logic [2:0] s, input logic clr = 1'b0);
    {red, green, yellow} = s;
    err_clr = clr;
    @(posedge clk);
    model_edge(s, clr);
    #1;
    chk("err", 8'(err), 8'(m_err));
    chk("err_code", 8'(err_code), 8'(m_code));
    chk("phase", 8'(phase), 8'(m_lamp));
    chk("cycles", cycles, 8'(m_cycles));
  endtask

  task automatic hold(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_err"}, 8'(err), 8'd0);
    chk({tag, "_code"}, 8'(err_code), 8'd0);
    chk({tag, "_phase"}, 8'(phase), 8'd0);
    chk({tag, "_cycles"}, cycles, 8'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [2:0] bad[4] = '{3'b000, 3'b011, 3'b110, 3'b111};

  initial begin
    int         cur, nxt, len, r;
    logic [2:0] s;
    logic       c;

    m_reset();
    #12;
    chk("rst_err", 8'(err), 8'd0);
    chk("rst_code", 8'(err_code), 8'd0);
    chk("rst_phase", 8'(phase), 8'd0);
    chk("rst_cycles", cycles, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    // Legal loop starting mid-red; the first loop is only partially observed.
    hold(R, 5); hold(G, 8); hold(Y, 3);
    repeat (2) begin hold(R, 10); hold(G, 8); hold(Y, 3); end
    hold(R, 10);
    chk("loop_cycles", cycles, DUR ? 8'd2 : 8'd3);
    chk("loop_err", 8'(err), 8'd0);
    chk("loop_phase", 8'(phase), 8'd1);

    // Red and green together during green.
    hold(G, 4);
    step(3'b110);
    chk("enc_err", 8'(err), 8'd1);
    chk("enc_code", 8'(err_code), 8'd1);
    chk("enc_phase", 8'(phase), 8'd0);
    hold(R, 10);
    step(G);
    chk("resync_phase", 8'(phase), 8'd2);

    step(G, 1'b1);
    chk("clr_err", 8'(err), 8'd0);
    chk("clr_code", 8'(err_code), 8'd0);

    // Full green followed straight by red.
    hold(G, 6);
    step(R);
    chk("order_code", 8'(err_code), 8'd2);
    chk("order_phase", 8'(phase), 8'd0);

`ifdef TLC_MON_DURATION_CHECK_EN
    step(G, 1'b1); hold(G, 7); hold(Y, 2);
    step(R);
    chk("short_code", 8'(err_code), 8'd3);
    step(G, 1'b1); hold(G, 7);
    step(G);
    chk("long_code", 8'(err_code), 8'd4);
    chk("long_phase", 8'(phase), 8'd0);
    step(3'b011);
    chk("sticky_code", 8'(err_code), 8'd4);
    step(R, 1'b1);
    chk("clr2_err", 8'(err), 8'd0);
    chk("clr2_code", 8'(err_code), 8'd0);
`else
    step(G, 1'b1); hold(G, 19); hold(Y, 3);
    step(R);
    chk("longgreen_err", 8'(err), 8'd0);
    chk("longgreen_cycles", cycles, 8'd4);
`endif

    // Clear on the same edge as a fresh illegal transition: the new error wins.
    step(3'b000);
    step(R);
    step(G);
    step(R, 1'b1);
    chk("clrwin_err", 8'(err), 8'd1);
    chk("clrwin_code", 8'(err_code), 8'd2);

    step(G); hold(G, 3);
    async_reset("midrst");
    hold(G, 4); hold(Y, 3); hold(R, 10);

    // Randomized traffic: mostly legal order and lengths, with mistakes mixed in.
    cur = 1;
    for (int p = 0; p < 250; p++) begin
      if (p == 120) async_reset("rndrst");
      r   = $urandom_range(0, 15);
      nxt = (r < 12) ? (cur % 3) + 1 : $urandom_range(1, 3);
      len = req[nxt];
      r   = $urandom_range(0, 7);
      if (r == 0) len = (req[nxt] > 1) ? req[nxt] - 1 : 1;
      else if (r == 1) len = req[nxt] + 1;
      else if (r == 2) len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        s = lampv(nxt);
        if ($urandom_range(0, 99) == 0) s = bad[$urandom_range(0, 3)];
        c = ($urandom_range(0, 31) == 0);
        step(s, c);
      end
      cur = nxt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
